// File: rtl/button_pulse_conditioner.sv
// Debounces BTN_W raw active-low pushbuttons into one-cycle active-low press pulses plus a clean level.
// Press/release are accepted DEBOUNCE_CYCLES+1 edges after the new raw level is first sampled.
module button_pulse_conditioner #(
    parameter int BTN_W           = 2,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BTN_W-1:0] btn_raw_n,
    output logic [BTN_W-1:0] press_n,
    output logic [BTN_W-1:0] btn_level
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_PRESSED,
        S_RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar g = 0; g < BTN_W; g++) begin : g_ch
        logic             r_meta_n;
        logic             r_sync_n;
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_press_n;
        logic             r_level;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_meta_n  <= 1'b1;
                r_sync_n  <= 1'b1;
                r_state   <= S_IDLE;
                r_cnt     <= CNT_ZERO;
                r_press_n <= 1'b1;
                r_level   <= 1'b0;
            end else begin
                r_meta_n  <= btn_raw_n[g];
                r_sync_n  <= r_meta_n;
                // Pulse is a single cycle: default high, only the accepting edge drives it low.
                r_press_n <= 1'b1;
                case (r_state)
                    S_IDLE: begin
                        if (!r_sync_n) begin
                            r_state <= S_PRESS_WAIT;
                            r_cnt   <= CNT_ONE;
                        end else begin
                            r_cnt   <= CNT_ZERO;
                        end
                    end
                    S_PRESS_WAIT: begin
                        if (r_sync_n) begin
                            r_state <= S_IDLE;
                            r_cnt   <= CNT_ZERO;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state   <= S_PRESSED;
                            r_cnt     <= CNT_ZERO;
                            r_press_n <= 1'b0;
                            r_level   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    S_PRESSED: begin
                        r_cnt <= CNT_ZERO;
                        if (r_sync_n) begin
                            r_state <= S_RELEASE_WAIT;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                    S_RELEASE_WAIT: begin
                        // A dip back low is bounce: return to PRESSED without a new pulse.
                        if (!r_sync_n) begin
                            r_state <= S_PRESSED;
                            r_cnt   <= CNT_ZERO;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= S_IDLE;
                            r_cnt   <= CNT_ZERO;
                            r_level <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= CNT_ZERO;
                    end
                endcase
            end
        end

        assign press_n[g]   = r_press_n;
        assign btn_level[g] = r_level;
    end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Bench for button_pulse_conditioner with DEBOUNCE_CYCLES=4: vector table plus pulse scoreboard.
module tb_button_pulse_conditioner;

    localparam int BTN_W = 2;
    localparam int DEB   = 4;
    localparam int NVEC  = 28;

    typedef struct {
        logic       rst;
        logic [1:0] raw_n;
        logic [1:0] exp_press_n;
        logic [1:0] exp_level;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [1:0] press_n;
    } pulse_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [BTN_W-1:0] btn_raw_n;
    logic [BTN_W-1:0] press_n;
    logic [BTN_W-1:0] btn_level;

    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    pulse_t sb_q[$];
    vec_t   vecs[NVEC];
    logic [1:0] bpat[6];

    always #5 clk = ~clk;

    button_pulse_conditioner #(
        .BTN_W          (BTN_W),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw_n(btn_raw_n),
        .press_n  (press_n),
        .btn_level(btn_level)
    );

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b, required %b", name, cyc, act, exp);
        end
    endtask

    task automatic expect_pulse(input int at, input logic [1:0] val);
        pulse_t p;
        p.cyc     = at;
        p.press_n = val;
        sb_q.push_back(p);
    endtask

    // Advance one clock; outputs are then stable and the scoreboard is consulted.
    task automatic tick();
        pulse_t p;
        @(negedge clk);
        cyc++;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            p = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse: press_n=%b due at cycle %0d never matched", p.press_n, p.cyc);
        end
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            p = sb_q.pop_front();
            check2("pulse", press_n, p.press_n);
        end else if (press_n !== 2'b11) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse at cycle %0d: got press_n=%b, required 11", cyc, press_n);
        end
    endtask

    task automatic run_until(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        int e0;
        int f;
        int r0;

        rst       = 1'b1;
        btn_raw_n = 2'b11;

        for (int i = 0; i < NVEC; i++) vecs[i] = '{1'b0, 2'b11, 2'b11, 2'b00};
        vecs[0].rst = 1'b1;
        for (int i = 1; i <= 8; i++) vecs[i].raw_n = 2'b10;
        vecs[6].exp_press_n = 2'b10;
        for (int i = 6; i <= 13; i++) vecs[i].exp_level = 2'b01;
        bpat = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 6; i++) vecs[16 + i].raw_n = bpat[i];

        // Reset, clean press, clean release, bounce rejection.
        for (int i = 0; i < NVEC; i++) begin
            rst       = vecs[i].rst;
            btn_raw_n = vecs[i].raw_n;
            if (vecs[i].exp_press_n != 2'b11) expect_pulse(cyc + 1, vecs[i].exp_press_n);
            tick();
            check2($sformatf("vec%0d_press_n", i), press_n, vecs[i].exp_press_n);
            check2($sformatf("vec%0d_level", i), btn_level, vecs[i].exp_level);
        end

        // Release with bounce on channel 0.
        btn_raw_n = 2'b10;
        e0 = cyc + 1;
        expect_pulse(e0 + DEB + 1, 2'b10);
        run_until(e0 + DEB + 3);
        check2("relb_pressed", btn_level, 2'b01);
        btn_raw_n = 2'b11;
        tick();
        check2("relb_b1", btn_level, 2'b01);
        tick();
        check2("relb_b2", btn_level, 2'b01);
        btn_raw_n = 2'b10;
        tick();
        check2("relb_b3", btn_level, 2'b01);
        btn_raw_n = 2'b11;
        f = cyc + 1;
        run_until(f + DEB);
        check2("relb_hold", btn_level, 2'b01);
        tick();
        check2("relb_fall", btn_level, 2'b00);
        run_until(cyc + 4);

        // Simultaneous press on both channels.
        btn_raw_n = 2'b00;
        e0 = cyc + 1;
        expect_pulse(e0 + DEB + 1, 2'b00);
        run_until(e0 + DEB);
        check2("sim_before", btn_level, 2'b00);
        tick();
        check2("sim_rise", btn_level, 2'b11);
        run_until(cyc + 3);
        btn_raw_n = 2'b11;
        run_until(cyc + 2 * DEB + 6);
        check2("sim_released", btn_level, 2'b00);

        // Reset while channel 0 is mid-debounce with the button held.
        btn_raw_n = 2'b10;
        e0 = cyc + 1;
        run_until(e0 + 3);
        rst = 1'b1;
        tick();
        check2("rst_press_n", press_n, 2'b11);
        check2("rst_level", btn_level, 2'b00);
        rst = 1'b0;
        r0 = cyc + 1;
        expect_pulse(r0 + DEB + 1, 2'b10);
        run_until(r0 + DEB);
        check2("rst_before", btn_level, 2'b00);
        tick();
        check2("rst_rise", btn_level, 2'b01);
        btn_raw_n = 2'b11;
        run_until(cyc + 2 * DEB + 6);
        check2("rst_released", btn_level, 2'b00);

        // Long hold on channel 1.
        btn_raw_n = 2'b01;
        e0 = cyc + 1;
        expect_pulse(e0 + DEB + 1, 2'b01);
        repeat (1000) begin
            tick();
            check2("hold_level", btn_level, (cyc >= e0 + DEB + 1) ? 2'b10 : 2'b00);
        end
        btn_raw_n = 2'b11;
        run_until(cyc + 2 * DEB + 6);
        check2("hold_released", btn_level, 2'b00);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected pulses outstanding, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
